// File: rtl/sobel_pkg.sv
`timescale 1ns/1ps
// Shared types for the Sobel frame controller: FSM states, error codes, header length.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE, HDR, CHECK, REPLAY, STREAM, DRAIN, DONE, ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_BAD_DIM, ERR_TIMEOUT, ERR_OVERRUN
  } err_t;

  localparam int HDR_BYTES = 4;

endpackage

// File: rtl/sobel_tx_fifo.sv
`timescale 1ns/1ps
// Show-ahead byte FIFO feeding UART TX; rd_data valid the cycle after a push, push into a full FIFO only lands when popped in the same cycle.
// flush empties it in one cycle; free reports the number of unused entries.
module sobel_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [7:0]             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_V);
  assign free    = DEPTH_V - count;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
`timescale 1ns/1ps
// Frame controller between UART and Sobel core: header parse/replay, byte accounting, TX buffering, error recovery.
// rx->core 1 cycle, core->tx 1 cycle; core throttled via core_ready. SOBEL_CTRL_ECHO_HDR_EN echoes the header to TX.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH      = 1024,
  parameter int MAX_HEIGHT     = 1024,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TX_FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       core_rst,
  output logic [7:0] core_data,
  output logic       core_valid,
  output logic       core_ready,
  input  logic [7:0] core_out_data,
  input  logic       core_out_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic [1:0] err
);
  localparam int FW = $clog2(TX_FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW:0]   FREE_MIN = (FW+1)'(2);
  localparam logic [15:0]   MAX_W    = 16'(MAX_WIDTH);
  localparam logic [15:0]   MAX_H    = 16'(MAX_HEIGHT);

  state_t        state, state_nxt;
  err_t          err_q, err_nxt;
  logic [7:0]    hdr_b [HDR_BYTES];
  logic [1:0]    hdr_idx;
  logic [31:0]   total, in_cnt, out_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    pix_dat;
  logic          pix_vld;
  logic [15:0]   width, height;
  logic          dim_ok, tmo_clr, tmo_hit, drop, out_phase;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_wdat;
  logic [FW:0]   fifo_free;

  assign width     = {hdr_b[1], hdr_b[0]};
  assign height    = {hdr_b[3], hdr_b[2]};
  assign dim_ok    = (width >= 16'd3) && (width <= MAX_W) && (height >= 16'd3) && (height <= MAX_H);
  assign out_phase = (state == STREAM) || (state == DRAIN);
  assign tmo_clr   = (state == DRAIN) ? core_out_valid : rx_valid;
  assign tmo_hit   = (tmo_cnt == TMO_LAST) && !tmo_clr;
  assign fifo_pop  = tx_valid & tx_ready;
  assign drop      = out_phase && core_out_valid && fifo_full && !fifo_pop;
  assign tx_valid  = ~fifo_empty;
  assign err       = err_q;

`ifdef SOBEL_CTRL_ECHO_HDR_EN
  assign fifo_push = (out_phase && core_out_valid) || (state == REPLAY);
  assign fifo_wdat = (state == REPLAY) ? hdr_b[hdr_idx] : core_out_data;
`else
  assign fifo_push = out_phase && core_out_valid;
  assign fifo_wdat = core_out_data;
`endif

  sobel_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdat),
    .pop       (fifo_pop),
    .flush     (state == ERROR),
    .rd_data   (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    err_nxt    = err_q;
    core_rst   = (state == IDLE) || (state == HDR) || (state == DONE) || (state == ERROR);
    busy       = (state != IDLE) && (state != ERROR);
    frame_done = (state == DONE);
    core_ready = out_phase && (fifo_free >= FREE_MIN);
    core_valid = (state == REPLAY) || pix_vld;
    core_data  = (state == REPLAY) ? hdr_b[hdr_idx] : pix_dat;
    case (state)
      IDLE: if (rx_valid) state_nxt = HDR;
      HDR: begin
        if (tmo_hit) begin
          state_nxt = ERROR; err_nxt = ERR_TIMEOUT;
        end else if (rx_valid && hdr_idx == 2'd3) state_nxt = CHECK;
      end
      CHECK: begin
        if (rx_valid) begin
          state_nxt = ERROR; err_nxt = ERR_OVERRUN;
        end else if (!dim_ok) begin
          state_nxt = ERROR; err_nxt = ERR_BAD_DIM;
        end else begin
          state_nxt = REPLAY; err_nxt = ERR_NONE;
        end
      end
      REPLAY: begin
        if (rx_valid) begin
          state_nxt = ERROR; err_nxt = ERR_OVERRUN;
        end else if (hdr_idx == 2'd3) state_nxt = STREAM;
      end
      STREAM: begin
        if (drop || (rx_valid && in_cnt == total)) begin
          state_nxt = ERROR; err_nxt = ERR_OVERRUN;
        end else if (tmo_hit) begin
          state_nxt = ERROR; err_nxt = ERR_TIMEOUT;
        end else if (rx_valid && (in_cnt + 32'd1 == total)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drop) begin
          state_nxt = ERROR; err_nxt = ERR_OVERRUN;
        end else if (tmo_hit) begin
          state_nxt = ERROR; err_nxt = ERR_TIMEOUT;
        end else if (out_cnt == total && fifo_empty) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // hdr_idx doubles as the replay pointer; it wraps to 0 on entering CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= ERR_NONE;
      hdr_b   <= '{default: 8'h00};
      hdr_idx <= 2'd0;
      total   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      pix_vld <= 1'b0;
      pix_dat <= 8'h00;
    end else begin
      err_q   <= err_nxt;
      pix_vld <= 1'b0;
      case (state)
        IDLE: begin
          hdr_idx <= rx_valid ? 2'd1 : 2'd0;
          if (rx_valid) hdr_b[0] <= rx_data;
        end
        HDR: if (rx_valid) begin
          hdr_b[hdr_idx] <= rx_data;
          hdr_idx        <= hdr_idx + 2'd1;
        end
        CHECK: begin
          total   <= 32'(width) * 32'(height);
          in_cnt  <= '0;
          out_cnt <= '0;
        end
        REPLAY: hdr_idx <= hdr_idx + 2'd1;
        STREAM: if (rx_valid && in_cnt != total) begin
          pix_vld <= 1'b1;
          pix_dat <= rx_data;
          in_cnt  <= in_cnt + 32'd1;
        end
        DONE, ERROR: begin
          hdr_idx <= 2'd0;
          total   <= '0;
          in_cnt  <= '0;
          out_cnt <= '0;
        end
        default: ;
      endcase
      if (out_phase && core_out_valid) out_cnt <= out_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt <= '0;
    else if (state == HDR || out_phase) tmo_cnt <= tmo_clr ? '0 : tmo_cnt + 1'b1;
    else tmo_cnt <= '0;
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
`timescale 1ns/1ps
// Directed bench for sobel_frame_ctrl with a behavioural core model honouring core_ready.
module tb_sobel_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       core_rst;
  logic [7:0] core_data;
  logic       core_valid;
  logic       core_ready;
  logic [7:0] core_out_data = 8'h00;
  logic       core_out_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       frame_done;
  logic [1:0] err;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .MAX_WIDTH(1024), .MAX_HEIGHT(1024), .TIMEOUT_CYCLES(100), .TX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .core_rst(core_rst), .core_data(core_data), .core_valid(core_valid), .core_ready(core_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

`ifdef SOBEL_CTRL_ECHO_HDR_EN
  localparam int ECHO = 1;
`else
  localparam int ECHO = 0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Negedge monitor: logs core-side strobes, TX handshakes and frame_done pulses
  logic [7:0] cv_log [0:1023];
  logic [7:0] tx_log [0:1023];
  int cv_n = 0;
  int tx_n = 0;
  int fd_n = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (core_valid) begin cv_log[cv_n] <= core_data; cv_n <= cv_n + 1; end
      if (tx_valid && tx_ready) begin tx_log[tx_n] <= tx_data; tx_n <= tx_n + 1; end
      if (frame_done) fd_n <= fd_n + 1;
    end
  end

  // Core model: emits byte (index + 0x30) whenever allowed and requested
  int core_req = 0;
  int core_sent = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst && core_ready && core_sent < core_req) begin
      core_out_valid = 1'b1;
      core_out_data  = 8'(core_sent + 48);
      core_sent      = core_sent + 1;
    end else begin
      core_out_valid = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] w, input logic [15:0] h);
    send(w[7:0]); send(w[15:8]); send(h[7:0]); send(h[15:8]);
  endtask

  task automatic frame(input string tag, input int w, input int h, input bit hold);
    int n, ntx, cv0, tx0, fd0, cs0;
    logic [15:0] wv, hv;
    logic [7:0]  hb [4];
    logic [7:0]  e;
    wv = 16'(w); hv = 16'(h);
    hb = '{wv[7:0], wv[15:8], hv[7:0], hv[15:8]};
    n = w * h; ntx = n + 4 * ECHO;
    cv0 = cv_n; tx0 = tx_n; fd0 = fd_n; cs0 = core_req;
    tx_ready = !hold;
    send_hdr(wv, hv);
    chk({tag, ":busy"}, 32'(busy), 1);
    idle(6);
    core_req = core_req + n;
    for (int i = 0; i < n; i++) begin
      send(8'(i * 3 + 1));
      if (i == 0) chk({tag, ":pix_lat"}, {23'd0, core_valid, core_data}, {23'd0, 1'b1, 8'd1});
      idle(1);
    end
    if (hold) begin
      idle(20);
      e = (ECHO != 0) ? hb[0] : 8'(cs0 + 48);
      chk({tag, ":core_rdy_low"}, 32'(core_ready), 0);
      chk({tag, ":core_sent_hold"}, core_sent - cs0, (ECHO != 0) ? 0 : 3);
      chk({tag, ":tx_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, e});
      tx_ready = 1'b1;
    end
    for (int i = 0; i < 400 && fd_n == fd0; i++) tick();
    idle(2);
    chk({tag, ":frame_done"}, fd_n - fd0, 1);
    chk({tag, ":cv_count"}, cv_n - cv0, n + 4);
    for (int i = 0; i < 4; i++) chk({tag, ":replay"}, 32'(cv_log[cv0 + i]), 32'(hb[i]));
    for (int i = 0; i < n; i++) chk({tag, ":pix"}, 32'(cv_log[cv0 + 4 + i]), 32'(8'(i * 3 + 1)));
    chk({tag, ":tx_count"}, tx_n - tx0, ntx);
    for (int j = 0; j < ntx; j++) begin
      if (ECHO != 0 && j < 4) e = hb[j];
      else e = 8'(cs0 + j - 4 * ECHO + 48);
      chk({tag, ":tx_byte"}, 32'(tx_log[tx0 + j]), 32'(e));
    end
    chk({tag, ":err"}, 32'(err), 0);
    chk({tag, ":idle"}, {30'd0, busy, core_rst}, 32'b01);
  endtask

  initial begin
    int k, cv0, fd0;
    idle(2);
    chk("rst:core_rst", 32'(core_rst), 1);
    chk("rst:err", 32'(err), 0);
    chk("rst:strobes", {27'd0, core_valid, tx_valid, busy, frame_done, core_ready}, 0);
    chk("rst:data", {16'd0, core_data, tx_data}, 0);
    rst = 1'b0;
    idle(2);

    frame("f5x4", 5, 4, 1'b0);

    cv0 = cv_n;
    send_hdr(16'd2, 16'd5);
    tick();
    chk("bad_dim:err", 32'(err), 1);
    chk("bad_dim:state", {30'd0, busy, core_rst}, 32'b01);
    tick();
    chk("bad_dim:held", 32'(err), 1);
    chk("bad_dim:no_core", cv_n - cv0, 0);
    frame("f3x3", 3, 3, 1'b0);

    frame("hold4x4", 4, 4, 1'b1);

    fd0 = fd_n;
    send_hdr(16'd4, 16'd4);
    idle(6);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) idle(1);
      send(8'(i + 100));
    end
    k = 0;
    while (k < 150 && err != 2'd2) begin tick(); k++; end
    chk("tmo:cycles", k, 100);
    chk("tmo:state", {29'd0, busy, core_rst, tx_valid}, 32'b010);
    tick();
    chk("tmo:held", 32'(err), 2);
    chk("tmo:no_done", fd_n - fd0, 0);

    send_hdr(16'd4, 16'd4);
    send(8'h55);
    chk("ovr:err", 32'(err), 3);
    chk("ovr:busy", 32'(busy), 0);
    tick();
    chk("ovr:idle", {29'd0, err, core_rst}, {29'd0, 2'd3, 1'b1});

    frame("recover", 3, 3, 1'b0);

    send_hdr(16'd4, 16'd4);
    idle(6);
    send(8'h11);
    idle(1);
    send(8'h22);
    rst = 1'b1;
    #1;
    chk("arst:outs", {28'd0, busy, core_rst, core_valid, core_ready}, 32'b0100);
    tick();
    rst = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
